mem_access_ctrl: RTL and testbench



---
 rtl/mem_access_ctrl.sv | 108 ++++++++++
 tb/tb_mem_access_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer for a variable-latency data memory.
// Freezes upstream stages while a req/ack access is outstanding.
module mem_access_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [31:0]      Addr,
  input  logic [31:0]      WriteData,
  input  logic             MemAck,
  input  logic [31:0]      MemRdata,
  output logic             MemReq,
  output logic             MemWe,
  output logic [31:0]      MemAddr,
  output logic [31:0]      MemWdata,
  output logic             Stall,
  output logic             WbValid,
  output logic [31:0]      ReadDataOut,
  output logic             Timeout,
  output logic [CNT_W-1:0] StallCount
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  // counter only needs to reach TIMEOUT-1: that REQ cycle is the last one
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [TW-1:0] tcnt;
  logic          mem_op;

  assign mem_op = MemRead | MemWrite;

  // pipeline freeze and MEM/WB capture decode
  always_comb begin
    Stall   = 1'b0;
    WbValid = 1'b0;
    if (!Rst) begin
      case (state)
        IDLE: begin
          Stall   = mem_op;
          WbValid = ~mem_op;
        end
        REQ:  Stall   = 1'b1;
        DONE: WbValid = 1'b1;
        default: Stall = 1'b1;
      endcase
    end
  end

  // access sequencing, request registers and read-data hold
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= IDLE;
      tcnt        <= '0;
      MemReq      <= 1'b0;
      MemWe       <= 1'b0;
      MemAddr     <= '0;
      MemWdata    <= '0;
      ReadDataOut <= '0;
      Timeout     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            MemAddr  <= Addr;
            MemWdata <= WriteData;
            MemWe    <= MemWrite;
            MemReq   <= 1'b1;
            tcnt     <= '0;
            state    <= REQ;
          end
        end
        REQ: begin
          if (MemAck) begin
            if (!MemWe) ReadDataOut <= MemRdata;
            MemReq <= 1'b0;
            state  <= DONE;
          end else if (tcnt == TLAST) begin
            MemReq  <= 1'b0;
            Timeout <= 1'b1;
            state   <= ERR;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= ERR;
      endcase
    end
  end

  // saturating count of stalled cycles
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      StallCount <= '0;
    else if (Stall && (StallCount != '1))
      StallCount <= StallCount + 1'b1;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl.
// Transaction-level model: stalls = 1 + ack delay, load data held.
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        MemRead, MemWrite, MemAck;
  logic [31:0] Addr, WriteData, MemRdata;

  logic        MemReq, MemWe, Stall, WbValid, Timeout;
  logic [31:0] MemAddr, MemWdata, ReadDataOut;
  logic [15:0] StallCount;

  logic        b_MemReq, b_MemWe, b_Stall, b_WbValid, b_Timeout;
  logic [31:0] b_MemAddr, b_MemWdata, b_ReadDataOut;
  logic [1:0]  b_StallCount;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_rdo;
  int          m_sc;

  mem_access_ctrl #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .Clk(Clk), .Rst(Rst),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .WriteData(WriteData),
    .MemAck(MemAck), .MemRdata(MemRdata),
    .MemReq(MemReq), .MemWe(MemWe),
    .MemAddr(MemAddr), .MemWdata(MemWdata),
    .Stall(Stall), .WbValid(WbValid),
    .ReadDataOut(ReadDataOut), .Timeout(Timeout),
    .StallCount(StallCount)
  );

  mem_access_ctrl #(.TIMEOUT(TO), .CNT_W(2)) dut_sat (
    .Clk(Clk), .Rst(Rst),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .WriteData(WriteData),
    .MemAck(MemAck), .MemRdata(MemRdata),
    .MemReq(b_MemReq), .MemWe(b_MemWe),
    .MemAddr(b_MemAddr), .MemWdata(b_MemWdata),
    .Stall(b_Stall), .WbValid(b_WbValid),
    .ReadDataOut(b_ReadDataOut), .Timeout(b_Timeout),
    .StallCount(b_StallCount)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  function automatic int sat2(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic test_reset();
    Rst = 1'b1; MemRead = 1'b1; MemWrite = 1'b0;
    MemAck = 1'b0; Addr = 32'h0; WriteData = 32'h0; MemRdata = 32'h0;
    @(posedge Clk); @(negedge Clk);
    checks++;
    if (Stall !== 1'b0 || WbValid !== 1'b0 || MemReq !== 1'b0)
      begin errors++; $display("FAIL reset_ctl: stall=%b wb=%b req=%b need 000",
        Stall, WbValid, MemReq); end
    checks++;
    if (MemWe !== 0 || MemAddr !== 0 || MemWdata !== 0 || ReadDataOut !== 0 ||
        Timeout !== 0 || StallCount !== 0)
      begin errors++; $display("FAIL reset_regs: we=%b a=%h wd=%h rd=%h to=%b sc=%0d need 0",
        MemWe, MemAddr, MemWdata, ReadDataOut, Timeout, StallCount); end
    MemRead = 1'b0;
    Rst = 1'b0;
    m_rdo = 32'h0; m_sc = 0;
    @(posedge Clk); #1;
  endtask

  task automatic nonmem(input string nm, input bit junk_ack);
    MemRead = 1'b0; MemWrite = 1'b0;
    Addr = $urandom; WriteData = $urandom;
    MemAck = junk_ack; MemRdata = $urandom;
    @(negedge Clk);
    checks++;
    if (Stall !== 0 || WbValid !== 1 || MemReq !== 0 || ReadDataOut !== m_rdo ||
        StallCount !== 16'(m_sc))
      begin errors++; $display("FAIL %s: stall=%b wb=%b req=%b rd=%h sc=%0d need 0 1 0 %h %0d",
        nm, Stall, WbValid, MemReq, ReadDataOut, StallCount, m_rdo, m_sc); end
    @(posedge Clk); #1;
    MemAck = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdat, input int ackn);
    int stalls;
    bit done;
    bit stable;
    stalls = 0; done = 0; stable = 1;
    MemRead = rd; MemWrite = wr; Addr = a; WriteData = wd;
    for (int c = 0; c <= TO + 2 && !done; c++) begin
      MemAck   = (c == ackn);
      MemRdata = (c == ackn) ? rdat : $urandom;
      @(negedge Clk);
      if (c >= 1 && Stall === 1'b1 &&
          (MemReq !== 1 || MemAddr !== a || MemWdata !== wd || MemWe !== wr))
        stable = 0;
      if (Stall === 1'b1) stalls++;
      else done = 1;
      if (!done) begin @(posedge Clk); #1; end
    end
    if (rd && !wr) m_rdo = rdat;
    m_sc += 1 + ackn;
    checks++;
    if (!done || stalls != 1 + ackn)
      begin errors++; $display("FAIL %s_stalls: got %0d need %0d", nm, stalls, 1 + ackn); end
    checks++;
    if (WbValid !== 1 || MemReq !== 0 || Timeout !== 0)
      begin errors++; $display("FAIL %s_done: wb=%b req=%b to=%b need 1 0 0",
        nm, WbValid, MemReq, Timeout); end
    checks++;
    if (ReadDataOut !== m_rdo)
      begin errors++; $display("FAIL %s_rdata: got %h need %h", nm, ReadDataOut, m_rdo); end
    checks++;
    if (!stable)
      begin errors++; $display("FAIL %s_hold: req/addr/data/we not stable, got %b need 1",
        nm, stable); end
    checks++;
    if (StallCount !== 16'(m_sc) || b_StallCount !== 2'(sat2(m_sc)))
      begin errors++; $display("FAIL %s_count: got %0d/%0d need %0d/%0d",
        nm, StallCount, b_StallCount, m_sc, sat2(m_sc)); end
    @(posedge Clk); #1;
    MemAck = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic test_nonmem();
    for (int i = 0; i < 4; i++) nonmem("nonmem", 1'b0);
  endtask

  task automatic test_load();
    run_op("load", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1);
  endtask

  task automatic test_store();
    run_op("store", 1'b0, 1'b1, 32'h10, 32'h1234, 32'hCAFE_F00D, 3);
  endtask

  task automatic test_ack_at_limit();
    run_op("acklim", 1'b1, 1'b0, 32'h80, 32'h0, 32'h5A5A_0001, TO);
    run_op("both", 1'b1, 1'b1, 32'h84, 32'h77, 32'h1111_2222, 2);
  endtask

  task automatic test_timeout();
    bit early_ok;
    early_ok = 1;
    MemRead = 1'b1; MemWrite = 1'b0; Addr = 32'h200; MemAck = 1'b0;
    for (int c = 0; c <= TO; c++) begin
      @(negedge Clk);
      if (Stall !== 1 || Timeout !== 0) early_ok = 0;
      @(posedge Clk); #1;
    end
    checks++;
    if (!early_ok)
      begin errors++; $display("FAIL timeout_early: got flag %b need 1", early_ok); end
    MemAck = 1'b1; MemRdata = 32'hFFFF_0000;
    @(negedge Clk);
    checks++;
    if (Timeout !== 1 || MemReq !== 0 || Stall !== 1 || WbValid !== 0)
      begin errors++; $display("FAIL timeout_err: to=%b req=%b stall=%b wb=%b need 1 0 1 0",
        Timeout, MemReq, Stall, WbValid); end
    repeat (3) @(posedge Clk);
    MemRead = 1'b0;
    MemAck = 1'b0;
    @(negedge Clk);
    checks++;
    if (Timeout !== 1 || Stall !== 1 || ReadDataOut !== m_rdo)
      begin errors++; $display("FAIL timeout_stuck: to=%b stall=%b rd=%h need 1 1 %h",
        Timeout, Stall, ReadDataOut, m_rdo); end
    Rst = 1'b1;
    #1;
    checks++;
    if (Timeout !== 0 || MemReq !== 0 || Stall !== 0 || WbValid !== 0 ||
        MemAddr !== 0 || MemWe !== 0 || ReadDataOut !== 0 || StallCount !== 0)
      begin errors++; $display("FAIL timeout_rst: to=%b req=%b stall=%b wb=%b a=%h sc=%0d need 0",
        Timeout, MemReq, Stall, WbValid, MemAddr, StallCount); end
    @(posedge Clk); #1;
    Rst = 1'b0;
    m_rdo = 32'h0; m_sc = 0;
    @(posedge Clk); #1;
    nonmem("after_err", 1'b0);
  endtask

  task automatic test_saturate();
    test_reset();
    run_op("sat", 1'b1, 1'b0, 32'h300, 32'h0, 32'h0BAD_F00D, TO);
    checks++;
    if (b_StallCount !== 2'd3)
      begin errors++; $display("FAIL saturate: got %0d need 3", b_StallCount); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    run_op("b2b0", 1'b1, 1'b0, 32'h400, 32'h0, 32'h0101_0101, 2);
    run_op("b2b1", 1'b1, 1'b0, 32'h404, 32'h0, 32'h0202_0202, 1);
    MemRead = 1'b1; Addr = 32'h408;
    @(posedge Clk); #1;
    #2 Rst = 1'b1;
    #1;
    checks++;
    if (MemReq !== 0 || Stall !== 0)
      begin errors++; $display("FAIL async_rst: req=%b stall=%b need 0 0", MemReq, Stall); end
    d = $urandom;
    MemAck = 1'b1; MemRdata = d;
    @(negedge Clk);
    Rst = 1'b0; MemRead = 1'b0;
    m_rdo = 32'h0; m_sc = 0;
    @(posedge Clk); #1;
    MemAck = 1'b0;
    @(negedge Clk);
    checks++;
    if (ReadDataOut !== 0 || MemReq !== 0 || Stall !== 0 || WbValid !== 1)
      begin errors++; $display("FAIL late_ack: rd=%h req=%b stall=%b wb=%b need 0 0 0 1",
        ReadDataOut, MemReq, Stall, WbValid); end
    @(posedge Clk); #1;
  endtask

  task automatic test_random();
    int kind;
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 3);
      if (kind == 0)
        nonmem("rnd_nonmem", 1'($urandom_range(0, 1)));
      else
        run_op("rnd", logic'(kind != 2), logic'(kind >= 2), $urandom, $urandom,
               $urandom, $urandom_range(1, TO));
    end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_load();
    test_store();
    test_ack_at_limit();
    test_timeout();
    test_saturate();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
